// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame engine: default 640x480@60 timing,
// sync polarity and display mode encoding.
package vga_pkg;

  localparam int unsigned VGA_HD = 640;
  localparam int unsigned VGA_HF = 16;
  localparam int unsigned VGA_HR = 96;
  localparam int unsigned VGA_HB = 48;
  localparam int unsigned VGA_VD = 480;
  localparam int unsigned VGA_VF = 10;
  localparam int unsigned VGA_VR = 2;
  localparam int unsigned VGA_VB = 33;

  // Level of the sync pulses while asserted; 640x480@60 uses negative sync.
  localparam logic SYNC_ACTIVE_LOW = 1'b0;

  typedef enum logic {
    MODE_SOLID = 1'b0,
    MODE_BARS  = 1'b1
  } mode_e;

endpackage

// File: rtl/vga_frame_engine_if.sv
// Host-side bus of the frame engine: output-register data, mode select and
// the FGO flag handshake.
interface vga_frame_engine_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] outr_outdata;
  logic              outr_valid;
  logic              display_mode;
  logic              flag_ack;
  logic              output_went_flag;

  modport master (
    output outr_outdata, outr_valid, display_mode, flag_ack,
    input  output_went_flag
  );

  modport slave (
    input  outr_outdata, outr_valid, display_mode, flag_ack,
    output output_went_flag
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable H/V raster counters with registered sync, blanking,
// coordinates and a frame-start pulse (one cycle behind the counters).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned HD     = VGA_HD,
  parameter int unsigned HF     = VGA_HF,
  parameter int unsigned HR     = VGA_HR,
  parameter int unsigned HB     = VGA_HB,
  parameter int unsigned VD     = VGA_VD,
  parameter int unsigned VF     = VGA_VF,
  parameter int unsigned VR     = VGA_VR,
  parameter int unsigned VB     = VGA_VB,
  parameter logic        HS_POL = SYNC_ACTIVE_LOW,
  parameter logic        VS_POL = SYNC_ACTIVE_LOW,
  localparam int unsigned H_TOTAL = HD + HF + HR + HB,
  localparam int unsigned V_TOTAL = VD + VF + VR + VB,
  localparam int unsigned HC_W    = $clog2(H_TOTAL),
  localparam int unsigned VC_W    = $clog2(V_TOTAL)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            hsynch,
  output logic            vsynch,
  output logic            video_on,
  output logic [HC_W-1:0] pixel_x,
  output logic [VC_W-1:0] pixel_y,
  output logic            frame_start,
  output logic [HC_W-1:0] hc,
  output logic            active_c,
  output logic            frame_end_c
);

  logic [HC_W-1:0] hc_q, hc_d;
  logic [VC_W-1:0] vc_q, vc_d;
  logic            hsynch_q, hsynch_d;
  logic            vsynch_q, vsynch_d;
  logic            video_on_q, video_on_d;
  logic [HC_W-1:0] pixel_x_q, pixel_x_d;
  logic [VC_W-1:0] pixel_y_q, pixel_y_d;
  logic            frame_start_q, frame_start_d;
  logic [31:0]     hc_u, vc_u;
  logic            line_end_c;

  // Counter advance plus decode of the current position into next outputs.
  always_comb begin
    hc_u        = 32'(hc_q);
    vc_u        = 32'(vc_q);
    hc_d        = hc_q + 1'b1;
    vc_d        = vc_q;
    line_end_c  = (hc_u == H_TOTAL - 1);
    frame_end_c = line_end_c && (vc_u == V_TOTAL - 1);
    active_c    = (hc_u < HD) && (vc_u < VD);

    if (line_end_c) begin
      hc_d = '0;
      vc_d = frame_end_c ? '0 : vc_q + 1'b1;
    end

    hsynch_d      = ((hc_u >= HD + HF) && (hc_u < HD + HF + HR)) ? HS_POL : ~HS_POL;
    vsynch_d      = ((vc_u >= VD + VF) && (vc_u < VD + VF + VR)) ? VS_POL : ~VS_POL;
    video_on_d    = active_c;
    pixel_x_d     = hc_q;
    pixel_y_d     = vc_q;
    frame_start_d = (hc_q == '0) && (vc_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      hsynch_q      <= ~HS_POL;
      vsynch_q      <= ~VS_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hsynch_q      <= hsynch_d;
      vsynch_q      <= vsynch_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsynch      = hsynch_q;
  assign vsynch      = vsynch_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;
  assign hc          = hc_q;

endmodule

// File: rtl/vga_frame_engine.sv
// VGA frame engine: tear-free data capture at frame boundaries, solid or
// bit-bar colour generation, and the full-frame-shown (FGO) flag.
module vga_frame_engine
  import vga_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned HD     = VGA_HD,
  parameter int unsigned HF     = VGA_HF,
  parameter int unsigned HR     = VGA_HR,
  parameter int unsigned HB     = VGA_HB,
  parameter int unsigned VD     = VGA_VD,
  parameter int unsigned VF     = VGA_VF,
  parameter int unsigned VR     = VGA_VR,
  parameter int unsigned VB     = VGA_VB,
  parameter logic        HS_POL = SYNC_ACTIVE_LOW,
  parameter logic        VS_POL = SYNC_ACTIVE_LOW,
  localparam int unsigned H_TOTAL = HD + HF + HR + HB,
  localparam int unsigned V_TOTAL = VD + VF + VR + VB,
  localparam int unsigned HC_W    = $clog2(H_TOTAL),
  localparam int unsigned VC_W    = $clog2(V_TOTAL),
  localparam int unsigned PC_W    = $clog2(HD * VD + 1),
  localparam int unsigned BAR_W   = HD / DATA_W
) (
  input  logic              mhz25_clock,
  input  logic              reset,
  vga_frame_engine_if.slave bus,
  output logic              hsynch,
  output logic              vsynch,
  output logic [DATA_W-1:0] rgb,
  output logic              video_on,
  output logic [HC_W-1:0]   pixel_x,
  output logic [VC_W-1:0]   pixel_y,
  output logic              frame_start
);

  logic [HC_W-1:0]   hc;
  logic              active_c;
  logic              frame_end_c;

  logic [DATA_W-1:0] pending_q, pending_d;
  logic              pending_valid_q, pending_valid_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  mode_e             mode_q, mode_d;
  logic              armed_q, armed_d;
  logic [PC_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;

  logic [31:0]       bar_idx_c;
  logic [DATA_W-1:0] bar_shift_c;

  vga_timing_gen #(
    .HD(HD), .HF(HF), .HR(HR), .HB(HB),
    .VD(VD), .VF(VF), .VR(VR), .VB(VB),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk         (mhz25_clock),
    .rst_n       (reset),
    .hsynch      (hsynch),
    .vsynch      (vsynch),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_start (frame_start),
    .hc          (hc),
    .active_c    (active_c),
    .frame_end_c (frame_end_c)
  );

  // Capture, frame-boundary handover and flag; later assignments take priority.
  always_comb begin
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    disp_d          = disp_q;
    mode_d          = mode_q;
    armed_d         = armed_q;
    pix_cnt_d       = pix_cnt_q;
    flag_d          = flag_q;

    if (bus.flag_ack) flag_d = 1'b0;

    if (armed_q && (pix_cnt_q == PC_W'(HD * VD))) begin
      flag_d  = 1'b1;
      armed_d = 1'b0;
    end else if (armed_q && active_c) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    if (frame_end_c) begin
      pix_cnt_d = '0;
      mode_d    = mode_e'(bus.display_mode);
      if (pending_valid_q) begin
        disp_d          = pending_q;
        pending_valid_d = 1'b0;
        armed_d         = 1'b1;
      end
    end

    if (bus.outr_valid) begin
      pending_d       = bus.outr_outdata;
      pending_valid_d = 1'b1;
      flag_d          = 1'b0;
    end
  end

  // Bar select by comparator chain; remainder columns fall into the last bar.
  always_comb begin
    bar_idx_c = '0;
    for (int unsigned i = 1; i < DATA_W; i++) begin
      if (32'(hc) >= i * BAR_W) bar_idx_c = i;
    end
    bar_shift_c = disp_q << bar_idx_c;

    rgb_d = '0;
    if (active_c) begin
      rgb_d = (mode_q == MODE_BARS) ? {DATA_W{bar_shift_c[DATA_W-1]}} : disp_q;
    end
  end

  always_ff @(posedge mhz25_clock or negedge reset) begin
    if (!reset) begin
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      disp_q          <= '0;
      mode_q          <= MODE_SOLID;
      armed_q         <= 1'b0;
      pix_cnt_q       <= '0;
      flag_q          <= 1'b0;
      rgb_q           <= '0;
    end else begin
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      disp_q          <= disp_d;
      mode_q          <= mode_d;
      armed_q         <= armed_d;
      pix_cnt_q       <= pix_cnt_d;
      flag_q          <= flag_d;
      rgb_q           <= rgb_d;
    end
  end

  assign rgb                  = rgb_q;
  assign bus.output_went_flag = flag_q;

endmodule

// File: tb/tb_vga_frame_engine.sv
// Directed bench for vga_frame_engine on a 12x7 raster (8x4 active), checking
// timing every cycle plus data latching, bar mode, flag and reset behaviour.
module tb_vga_frame_engine;

  localparam int HT = 12;
  localparam int FT = 84;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsynch, vsynch, video_on, frame_start;
  logic [7:0] rgb;
  logic [3:0] pixel_x;
  logic [2:0] pixel_y;

  always #5 clk = ~clk;

  vga_frame_engine_if #(.DATA_W(8)) bus ();

  vga_frame_engine #(
    .DATA_W(8), .HD(8), .HF(1), .HR(2), .HB(1),
    .VD(4), .VF(1), .VR(1), .VB(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .mhz25_clock (clk),
    .reset       (rst_n),
    .bus         (bus),
    .hsynch      (hsynch),
    .vsynch      (vsynch),
    .rgb         (rgb),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_start (frame_start)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  int         k      = 0;
  int         fbase  = 0;
  logic [7:0] f_data [9];
  bit         f_bars [9];
  logic [7:0] bar_a1 [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rgb"},      32'(rgb), 32'h0);
    chk({tag, "_hsynch"},   32'(hsynch), 32'h1);
    chk({tag, "_vsynch"},   32'(vsynch), 32'h1);
    chk({tag, "_video_on"}, 32'(video_on), 32'h0);
    chk({tag, "_pixel_x"},  32'(pixel_x), 32'h0);
    chk({tag, "_pixel_y"},  32'(pixel_y), 32'h0);
    chk({tag, "_fstart"},   32'(frame_start), 32'h0);
    chk({tag, "_flag"},     32'(bus.output_went_flag), 32'h0);
  endtask

  // Sample k shows raster position k-1 (one-cycle output latency).
  task automatic check_cycle();
    int pos, x, y, f;
    logic [7:0] er;
    pos = (k - 1) % FT;
    x   = pos % HT;
    y   = pos / HT;
    f   = (k - 1) / FT + fbase;
    er  = 8'h00;
    if (x < 8 && y < 4) er = f_bars[f] ? bar_a1[x] : f_data[f];
    chk("pixel_x",  32'(pixel_x), x);
    chk("pixel_y",  32'(pixel_y), y);
    chk("hsynch",   32'(hsynch), (x == 9 || x == 10) ? 0 : 1);
    chk("vsynch",   32'(vsynch), (y == 5) ? 0 : 1);
    chk("video_on", 32'(video_on), (x < 8 && y < 4) ? 1 : 0);
    chk("fstart",   32'(frame_start), (pos == 0) ? 1 : 0);
    chk("rgb",      32'(rgb), 32'(er));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
    check_cycle();
  endtask

  task automatic run_to(input int n);
    while (k < n) step();
  endtask

  task automatic strobe(input logic [7:0] d);
    bus.outr_valid   = 1'b1;
    bus.outr_outdata = d;
    step();
    bus.outr_valid   = 1'b0;
  endtask

  initial begin
    f_data = '{8'h00, 8'hE3, 8'hE3, 8'hA1, 8'hA1, 8'h22, 8'h44, 8'h33, 8'h00};
    f_bars = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bar_a1 = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    bus.outr_outdata = 8'h00;
    bus.outr_valid   = 1'b0;
    bus.display_mode = 1'b0;
    bus.flag_ack     = 1'b0;

    repeat (3) @(negedge clk);
    check_reset("rst");

    // Frame 0 blank, frame 1 shows E3 solid.
    rst_n = 1'b1;
    strobe(8'hE3);
    run_to(128);
    chk("flag_last_px", 32'(bus.output_went_flag), 32'h0);
    step();
    chk("flag_set1", 32'(bus.output_went_flag), 32'h1);
    run_to(170);
    chk("flag_hold", 32'(bus.output_went_flag), 32'h1);
    bus.flag_ack = 1'b1;
    step();
    bus.flag_ack = 1'b0;
    chk("flag_ack", 32'(bus.output_went_flag), 32'h0);

    // Bar mode with A1, requested mid frame 2, shown from frame 3.
    run_to(172);
    bus.display_mode = 1'b1;
    strobe(8'hA1);
    run_to(296);
    chk("flag_pre3", 32'(bus.output_went_flag), 32'h0);
    step();
    chk("flag_set3", 32'(bus.output_went_flag), 32'h1);

    // Two strobes in frame 4: last wins; strobe clears a set flag at once.
    run_to(340);
    chk("flag_hold4", 32'(bus.output_went_flag), 32'h1);
    strobe(8'h11);
    chk("flag_clr_valid", 32'(bus.output_went_flag), 32'h0);
    run_to(345);
    bus.display_mode = 1'b0;
    strobe(8'h22);
    run_to(464);
    chk("flag_pre5", 32'(bus.output_went_flag), 32'h0);
    step();
    chk("flag_set5", 32'(bus.output_went_flag), 32'h1);

    // Pending 44, then a strobe on the boundary cycle: 44 shown first, 33 next.
    run_to(470);
    strobe(8'h44);
    chk("flag_clr_valid2", 32'(bus.output_went_flag), 32'h0);
    run_to(503);
    strobe(8'h33);
    run_to(548);
    chk("flag_pre6", 32'(bus.output_went_flag), 32'h0);
    step();
    chk("flag_set6", 32'(bus.output_went_flag), 32'h1);

    // Asynchronous reset mid-line while frame 7 shows 33.
    run_to(595);
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    @(negedge clk);
    check_reset("held_rst");
    rst_n = 1'b1;
    k     = 0;
    fbase = 8;
    run_to(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_engine.md
Name: vga_frame_engine

Overview:
- Parametrised successor to the fixed 640x480 VGA output interface. Generates programmable H/V timing with selectable sync polarity, and registered pixel coordinates.
- Displays the output-register byte in one of two modes: solid colour, or a per-bit bar pattern.
- Latches new data only at frame boundaries, so the screen never tears.
- Raises output_went_flag to FGO once a full frame of the current data has been shown; the flag is held until acknowledged.

Parameters:
- DATA_W, 8, width of outr_outdata and rgb (rgb[7:5] R, [4:2] G, [1:0] B when 8).
- HD, 640, horizontal active pixels.
- HF, 16, horizontal front porch.
- HR, 96, hsync pulse width.
- HB, 48, horizontal back porch.
- VD, 480, vertical active lines.
- VF, 10, vertical front porch.
- VR, 2, vsync pulse width.
- VB, 33, vertical back porch.
- HS_POL, 0, hsynch active level (0 = active low).
- VS_POL, 0, vsynch active level.
- Derived: H_TOTAL=HD+HF+HR+HB, V_TOTAL=VD+VF+VR+VB, HC_W=$clog2(H_TOTAL), VC_W=$clog2(V_TOTAL).

Ports:
- mhz25_clock  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- outr_outdata  in  DATA_W  output register data.
- outr_valid  in  1  one-cycle strobe: outr_outdata holds new data.
- display_mode  in  1  0 = solid colour, 1 = bit bars.
- flag_ack  in  1  FGO acknowledge; clears output_went_flag.
- hsynch  out  1  horizontal sync, registered.
- vsynch  out  1  vertical sync, registered.
- rgb  out  DATA_W  pixel colour, registered.
- video_on  out  1  high during active area, registered.
- pixel_x  out  HC_W  current column, registered.
- pixel_y  out  VC_W  current line, registered.
- frame_start  out  1  one-cycle pulse at pixel (0,0).
- output_went_flag  out  1  full frame of the current data displayed.

Behaviour:
- Reset (reset=0, async):
  - hc, vc, pending, display register, pixel counter all 0; pending_valid=0.
  - rgb=0, video_on=0, pixel_x=0, pixel_y=0, frame_start=0, output_went_flag=0.
  - hsynch=~HS_POL, vsynch=~VS_POL.
  - Reset mid-frame restarts at (0,0) on the first clock after release.
- Counters:
  - hc runs 0..H_TOTAL-1 and wraps to 0.
  - vc increments when hc wraps, and wraps to 0 after V_TOTAL-1.
- Line/frame order: active, front porch, sync, back porch.
  - hsync active while HD+HF <= hc < HD+HF+HR.
  - vsync active while VD+VF <= vc < VD+VF+VR.
  - video_on while hc<HD and vc<VD.
- All outputs are registered from (hc,vc): 1-cycle latency, i.e. outputs reflect the counter value of the previous cycle.
- frame_start is 1 for exactly the cycle in which the outputs show (0,0).
- Data capture:
  - When outr_valid=1: pending<=outr_outdata, pending_valid<=1, output_went_flag<=0.
  - Back-to-back strobes: the last one wins.
- Frame boundary (hc=H_TOTAL-1 and vc=V_TOTAL-1):
  - If pending_valid: display register <= pending, pending_valid<=0, armed<=1.
  - display_mode is sampled into mode_q. Changing the mode never changes the frame in progress.
- Pixel colour when video_on, otherwise rgb=0:
  - mode_q=0: rgb = display register.
  - mode_q=1: the screen is DATA_W vertical bars, each BAR_W=HD/DATA_W wide.
  - Bar i = min(hc/BAR_W, DATA_W-1); remainder columns join the last bar.
  - Bar i shows all-ones if display bit [DATA_W-1-i] is 1, else 0.
  - Bar index is computed by a comparator chain or counter, not a divider.
- Flag:
  - While armed, the pixel counter counts active pixels of the current frame; it is cleared at each frame boundary.
  - When the count reaches HD*VD (last active pixel), set output_went_flag=1 and armed=0.
  - The flag is held until flag_ack=1 or outr_valid=1.
- Simultaneous events:
  - outr_valid and flag-set in the same cycle: outr_valid wins (flag 0, new pending).
  - flag_ack and flag-set in the same cycle: the flag sets.
  - outr_valid on the frame-boundary cycle: the new data goes to pending and is shown from the next frame; the old pending is transferred this boundary.
- Arithmetic: unsigned.
  - The pixel counter is $clog2(HD*VD+1) bits wide.
  - All counters saturate/wrap only as stated above.

Decomposition:
- Shared package vga_pkg:
  - 640x480@60 timing constants.
  - The mode enum MODE_SOLID=0, MODE_BARS=1.
  - A sync-polarity localparam.
- One sub-module, vga_timing_gen (counters, sync, video_on, coordinates, frame_start). The top level adds data capture, colour generation and the flag.

Test Plan:
- Small timing (HD=8,HF=1,HR=2,HB=1,VD=4,VF=1,VR=1,VB=1) -> hsynch low for hc 9..10 and vsynch low for vc 5; frame_start once every 12*7=84 cycles.
- Reset released, outr_valid with 8'hE3, mode 0 -> rgb=0 for the rest of frame 0; from the next frame_start, every active pixel is 8'hE3 and blanking is 0.
- After that frame's last active pixel -> output_went_flag=1 the next cycle; it stays 1 until flag_ack pulses, then goes 0.
- Mode 1 with data 8'b10100001 -> per line, bars 0, 2 and 7 are 8'hFF and the others are 0 (BAR_W=1 at HD=8).
- outr_valid 8'h11 then 8'h22 within one frame -> the next frame shows only 8'h22; outr_valid mid-frame while the flag is 1 clears the flag immediately.
- Assert reset mid-line with rgb!=0 -> all outputs take their reset values asynchronously; after release, pixel_x/pixel_y restart at 0 and hsynch equals ~HS_POL.
